// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with post-reset clear sweep,
// same-cycle write-to-read bypass and highest-port-wins write priority.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int N_RD     = 2,
    parameter int N_WR     = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_RD-1:0]          rd_ena,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD*DATA_W-1:0]   rd_data,
    input  logic [N_WR-1:0]          wr_ena,
    input  logic [N_WR*ADDR_W-1:0]   wr_addr,
    input  logic [N_WR*DATA_W-1:0]   wr_data,
    output logic                     init_busy,
    output logic                     wr_conflict
);
    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] READY = 2'd1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] sweep_ptr;
    logic [DATA_W-1:0] regs [DEPTH];
    logic [N_WR-1:0]   wr_ok;
    logic [N_RD-1:0]   rd_ok;
    logic              conflict;

    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(DEPTH)) && !(ZERO_REG != 0 && a == '0);
    endfunction

    assign init_busy = (state == INIT);

    always_comb begin
        wr_ok = '0;
        rd_ok = '0;
        for (int j = 0; j < N_WR; j++)
            wr_ok[j] = (state == READY) && wr_ena[j] && legal(wr_addr[j*ADDR_W +: ADDR_W]);
        for (int i = 0; i < N_RD; i++)
            rd_ok[i] = (state == READY) && rd_ena[i] && legal(rd_addr[i*ADDR_W +: ADDR_W]);
    end

    // Only writes that will actually commit can collide.
    always_comb begin
        conflict = 1'b0;
        for (int j = 0; j < N_WR; j++)
            for (int k = j + 1; k < N_WR; k++)
                if (wr_ok[j] && wr_ok[k] &&
                    wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W])
                    conflict = 1'b1;
    end

    // Ascending port scan: the last matching (highest) port overrides.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_RD; i++)
            if (rd_ok[i]) begin
                rd_data[i*DATA_W +: DATA_W] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
                for (int j = 0; j < N_WR; j++)
                    if (BYPASS != 0 && wr_ok[j] &&
                        wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])
                        rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
            end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INIT;
            sweep_ptr   <= '0;
            wr_conflict <= 1'b0;
        end else if (state == INIT) begin
            regs[sweep_ptr] <= '0;
            sweep_ptr       <= sweep_ptr + 1'b1;
            wr_conflict     <= 1'b0;
            if (sweep_ptr == ADDR_W'(DEPTH - 1))
                state <= READY;
        end else begin
            for (int j = 0; j < N_WR; j++)
                if (wr_ok[j])
                    regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
            wr_conflict <= conflict;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks on a default instance (32x32, 2R/2W, bypass)
// and a 24-deep, 4R/3W, no-bypass instance, plus a short scoreboard run on the latter.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rd_ena = '0;
    logic [9:0]   rd_addr = '0;
    logic [63:0]  rd_data;
    logic [1:0]   wr_ena = '0;
    logic [9:0]   wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic         init_busy, wr_conflict;

    logic [3:0]   rd_ena_b = '0;
    logic [19:0]  rd_addr_b = '0;
    logic [127:0] rd_data_b;
    logic [2:0]   wr_ena_b = '0;
    logic [14:0]  wr_addr_b = '0;
    logic [95:0]  wr_data_b = '0;
    logic         busy_b, conf_b;

    int n_cmp = 0;
    int n_fail = 0;

    regfile_mp dut (
        .clk(clk), .rst_n(rst_n),
        .rd_ena(rd_ena), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_busy(init_busy), .wr_conflict(wr_conflict)
    );

    regfile_mp #(.DEPTH(24), .N_RD(4), .N_WR(3), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_ena(rd_ena_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_ena(wr_ena_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .init_busy(busy_b), .wr_conflict(conf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_sweep(input string tag);
        int c1 = 0;
        int c2 = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (c1 == 0 && !init_busy) begin c1 = k; wr_ena = '0; end
            if (c2 == 0 && !busy_b) begin c2 = k; wr_ena_b = '0; end
            if (c1 != 0 && c2 != 0) break;
        end
        wr_ena = '0;
        wr_ena_b = '0;
        n_cmp++;
        if (c1 !== 32) begin n_fail++; $display("FAIL %s sweep32 cycles got %0d want 32", tag, c1); end
        n_cmp++;
        if (c2 !== 24) begin n_fail++; $display("FAIL %s sweep24 cycles got %0d want 24", tag, c2); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rd_ena = 2'b11; rd_addr = {5'd3, 5'd3};
        rd_ena_b = 4'hF; rd_addr_b = {4{5'd3}};
        wr_ena = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hAAAA_5555};
        wr_ena_b = 3'b001; wr_addr_b = {10'd0, 5'd3}; wr_data_b = {64'h0, 32'hAAAA_5555};
        repeat (3) tick();
        n_cmp++;
        if (init_busy !== 1'b1 || busy_b !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b/%b want 1/1", init_busy, busy_b); end
        n_cmp++;
        if (rd_data !== 64'h0 || rd_data_b !== 128'h0) begin n_fail++; $display("FAIL reset_rd got %h/%h want 0", rd_data, rd_data_b); end
        n_cmp++;
        if (wr_conflict !== 1'b0 || conf_b !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got %b/%b want 0", wr_conflict, conf_b); end
        rst_n = 1'b1;
        count_sweep("initial");
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #1;
            n_cmp++;
            if (rd_data !== 64'h0) begin n_fail++; $display("FAIL clear_r%0d got %h want 0", a, rd_data); end
        end
        rd_addr_b = {4{5'd3}};
        #1;
        n_cmp++;
        if (rd_data_b !== 128'h0) begin n_fail++; $display("FAIL clear_b_r3 got %h want 0", rd_data_b); end
    endtask

    task automatic test_write_read();
        rd_ena = 2'b11; rd_addr = {5'd5, 5'd5};
        wr_ena = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEAD_BEEF};
        rd_ena_b = 4'b0001; rd_addr_b = {15'd0, 5'd5};
        wr_ena_b = 3'b001; wr_addr_b = {10'd0, 5'd5}; wr_data_b = {64'h0, 32'hDEAD_BEEF};
        #1;
        n_cmp++;
        if (rd_data !== {2{32'hDEAD_BEEF}}) begin n_fail++; $display("FAIL bypass_r5 got %h want deadbeefdeadbeef", rd_data); end
        n_cmp++;
        if (rd_data_b[31:0] !== 32'h0) begin n_fail++; $display("FAIL nobypass_r5 got %h want 0", rd_data_b[31:0]); end
        tick();
        wr_ena = '0; wr_ena_b = '0;
        #1;
        n_cmp++;
        if (rd_data !== {2{32'hDEAD_BEEF}}) begin n_fail++; $display("FAIL stored_r5 got %h want deadbeefdeadbeef", rd_data); end
        n_cmp++;
        if (rd_data_b[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stored_b_r5 got %h want deadbeef", rd_data_b[31:0]); end
    endtask

    task automatic test_conflict();
        rd_ena = 2'b11; rd_addr = {5'd7, 5'd7};
        wr_ena = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        #1;
        n_cmp++;
        if (rd_data !== {32'h22, 32'h22}) begin n_fail++; $display("FAIL bypass_prio_r7 got %h want 22/22", rd_data); end
        n_cmp++;
        if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_early got %b want 0", wr_conflict); end
        tick();
        wr_ena = '0;
        #1;
        n_cmp++;
        if (wr_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_pulse got %b want 1", wr_conflict); end
        n_cmp++;
        if (rd_data[31:0] !== 32'h22) begin n_fail++; $display("FAIL stored_r7 got %h want 22", rd_data[31:0]); end
        tick();
        n_cmp++;
        if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL conflict_clear got %b want 0", wr_conflict); end
        wr_ena_b = 3'b111; wr_addr_b = {5'd9, 5'd9, 5'd9}; wr_data_b = {32'h33, 32'h22, 32'h11};
        rd_ena_b = 4'b0001; rd_addr_b = {15'd0, 5'd9};
        tick();
        wr_ena_b = '0;
        #1;
        n_cmp++;
        if (rd_data_b[31:0] !== 32'h33 || conf_b !== 1'b1) begin n_fail++; $display("FAIL b_prio_r9 got %h/%b want 33/1", rd_data_b[31:0], conf_b); end
    endtask

    task automatic test_zero_range();
        rd_ena = 2'b11; rd_addr = {5'd0, 5'd0};
        wr_ena = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {2{32'hFFFF_FFFF}};
        rd_ena_b = 4'b0011; rd_addr_b = {10'd0, 5'd23, 5'd30};
        wr_ena_b = 3'b111; wr_addr_b = {5'd23, 5'd30, 5'd30}; wr_data_b = {32'h5A, 32'h77, 32'h66};
        #1;
        n_cmp++;
        if (rd_data !== 64'h0) begin n_fail++; $display("FAIL zero_bypass got %h want 0", rd_data); end
        tick();
        wr_ena = '0; wr_ena_b = '0;
        #1;
        n_cmp++;
        if (wr_conflict !== 1'b0) begin n_fail++; $display("FAIL zero_conflict got %b want 0", wr_conflict); end
        n_cmp++;
        if (rd_data !== 64'h0) begin n_fail++; $display("FAIL zero_stored got %h want 0", rd_data); end
        n_cmp++;
        if (conf_b !== 1'b0) begin n_fail++; $display("FAIL range_conflict got %b want 0", conf_b); end
        n_cmp++;
        if (rd_data_b[63:0] !== {32'h5A, 32'h0}) begin n_fail++; $display("FAIL range_rd got %h want 0000005a00000000", rd_data_b[63:0]); end
    endtask

    task automatic test_rd_ena();
        wr_ena = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h1234};
        tick();
        wr_ena = '0;
        rd_ena = 2'b00; rd_addr = {5'd5, 5'd5};
        #1;
        n_cmp++;
        if (rd_data !== 64'h0) begin n_fail++; $display("FAIL rd_ena_off got %h want 0", rd_data); end
        rd_ena = 2'b10;
        #1;
        n_cmp++;
        if (rd_data !== {32'h1234, 32'h0}) begin n_fail++; $display("FAIL rd_ena_mixed got %h want 0000123400000000", rd_data); end
    endtask

    task automatic test_mid_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (init_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", init_busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_sweep("restart");
        rd_ena = 2'b11; rd_addr = {5'd7, 5'd5};
        #1;
        n_cmp++;
        if (rd_data !== 64'h0) begin n_fail++; $display("FAIL mid_cleared got %h want 0", rd_data); end
    endtask

    task automatic test_random();
        logic [31:0] model [24];
        logic [4:0]  wa [3];
        logic [31:0] wd [3];
        logic [2:0]  we;
        logic        exp_conf;
        int          bad = 0;
        rd_ena = '0; wr_ena = '0;
        for (int r = 0; r < 24; r++) model[r] = '0;
        model[5] = 32'hDEAD_BEEF; model[9] = 32'h33; model[23] = 32'h5A;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        count_sweep("random_init");
        for (int r = 0; r < 24; r++) model[r] = '0;
        for (int c = 0; c < 3000 && bad < 10; c++) begin
            we = 3'($urandom_range(0, 7));
            for (int j = 0; j < 3; j++) begin
                wa[j] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
                wd[j] = $urandom;
                wr_addr_b[j*5 +: 5] = wa[j];
                wr_data_b[j*32 +: 32] = wd[j];
            end
            wr_ena_b = we;
            rd_ena_b = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) rd_addr_b[i*5 +: 5] = 5'($urandom_range(0, 31));
            #1;
            for (int i = 0; i < 4; i++) begin
                logic [4:0]  ra = rd_addr_b[i*5 +: 5];
                logic [31:0] ex = (rd_ena_b[i] && ra < 24 && ra != 0) ? model[ra] : 32'h0;
                n_cmp++;
                if (rd_data_b[i*32 +: 32] !== ex) begin
                    n_fail++; bad++;
                    $display("FAIL rand_rd c%0d p%0d a%0d got %h want %h", c, i, ra, rd_data_b[i*32 +: 32], ex);
                end
            end
            exp_conf = 1'b0;
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 3; k++)
                    if (j != k && we[j] && we[k] && wa[j] == wa[k] && wa[j] < 24 && wa[j] != 0) exp_conf = 1'b1;
            for (int j = 0; j < 3; j++)
                if (we[j] && wa[j] < 24 && wa[j] != 0) model[wa[j]] = wd[j];
            tick();
            n_cmp++;
            if (conf_b !== exp_conf) begin
                n_fail++; bad++;
                $display("FAIL rand_conflict c%0d got %b want %b", c, conf_b, exp_conf);
            end
        end
        wr_ena_b = '0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_conflict();
        test_zero_range();
        test_rd_ena();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
